// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: latches a pattern, length and repeat count on start,
// then shifts the pattern out MSB-first, one bit per clock, for (repeat+1) passes.
//
// state | meaning
// IDLE  | ready for a new transfer; start is accepted here
// SHIFT | one pattern bit per cycle on dout_bit_o, dout_valid_o high
// DONE  | single-cycle done pulse, then back to IDLE
module seq_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [REP_W-1:0] repeat_cnt_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             dout_bit_o,
    output logic             dout_valid_o,
    output logic             done_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   pass_q, pass_d;

    logic               ready_q, ready_d;
    logic               bit_q, bit_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [LEN_W-1:0]   len_clamp;

    always_comb begin
        len_clamp = length_i;
        if (length_i > LEN_W'(WIDTH)) begin
            len_clamp = LEN_W'(WIDTH);
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pat_d  = pattern_i;
                    len_d  = len_clamp;
                    pass_d = repeat_cnt_i;
                    idx_d  = IDX_W'(len_clamp - LEN_W'(1));
                    state_d = (len_clamp == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (pass_q != '0) begin
                    // next pass follows with no gap cycle
                    pass_d = pass_q - REP_W'(1);
                    idx_d  = IDX_W'(len_q - LEN_W'(1));
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        ready_d = (state_d == IDLE);
        valid_d = (state_d == SHIFT);
        done_d  = (state_d == DONE);
        bit_d   = valid_d & pat_d[idx_d];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
            ready_q <= 1'b1;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            ready_q <= ready_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign ready_o      = ready_q;
    assign dout_bit_o   = bit_q;
    assign dout_valid_o = valid_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based model of the expected output stream plus
// hand-computed literal checks of bit streams, valid counts and done pulses.
module tb_seq_pattern_gen;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       start_i;
    logic [7:0] pattern_i;
    logic [3:0] length_i;
    logic [3:0] repeat_cnt_i;
    logic       abort_i;
    logic       ready_o;
    logic       dout_bit_o;
    logic       dout_valid_o;
    logic       done_o;

    int n_chk  = 0;
    int n_fail = 0;

    seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REP_W(4)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .pattern_i    (pattern_i),
        .length_i     (length_i),
        .repeat_cnt_i (repeat_cnt_i),
        .abort_i      (abort_i),
        .ready_o      (ready_o),
        .dout_bit_o   (dout_bit_o),
        .dout_valid_o (dout_valid_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Model: kind 0 = idle, 1 = data bit, 2 = done pulse
    typedef struct packed {
        logic [1:0] kind;
        logic       b;
    } ent_t;

    ent_t q[$];
    ent_t cur = 3'b000;
    int   m_len;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q.delete();
            cur = 3'b000;
        end else if (cur.kind == 2'd1 && abort_i) begin
            q.delete();
            cur = 3'b000;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.kind == 2'd0 && start_i) begin
            m_len = (length_i > 4'd8) ? 8 : int'(length_i);
            for (int r = 0; r <= int'(repeat_cnt_i); r++) begin
                for (int i = m_len - 1; i >= 0; i--) begin
                    q.push_back({2'd1, pattern_i[i]});
                end
            end
            q.push_back({2'd2, 1'b0});
            cur = q.pop_front();
        end else begin
            cur = 3'b000;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [63:0] stream = '0;
    int vcnt = 0;
    int dcnt = 0;
    int vbase = 0;
    int dbase = 0;

    always @(negedge clk_i) begin
        chk("ready",  64'(ready_o),      64'(cur.kind == 2'd0));
        chk("valid",  64'(dout_valid_o), 64'(cur.kind == 2'd1));
        chk("bit",    64'(dout_bit_o),   64'(cur.kind == 2'd1 && cur.b));
        chk("done",   64'(done_o),       64'(cur.kind == 2'd2));
        if (dout_valid_o) begin
            stream = {stream[62:0], dout_bit_o};
            vcnt++;
        end
        if (done_o) dcnt++;
    end

    task automatic cyc();
        @(negedge clk_i);
        #1;
    endtask

    task automatic snap();
        vbase = vcnt;
        dbase = dcnt;
    endtask

    task automatic xfer(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep);
        pattern_i    = pat;
        length_i     = len;
        repeat_cnt_i = rep;
        start_i      = 1'b1;
        cyc();
        start_i      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        pattern_i = '0; length_i = '0; repeat_cnt_i = '0;
        #1 rst_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(dout_valid_o), 64'd0);
        chk("rst_done",  64'(done_o), 64'd0);
        rst_n_i = 1'b1;
        cyc();

        // single pass
        snap();
        xfer(8'h0A, 4'd4, 4'd0);
        repeat (6) cyc();
        chk("t1_stream", 64'(stream[3:0]), 64'hA);
        chk("t1_vcnt", 64'(vcnt - vbase), 64'd4);
        chk("t1_dcnt", 64'(dcnt - dbase), 64'd1);

        // repeats, no gaps
        snap();
        xfer(8'h03, 4'd4, 4'd2);
        repeat (14) cyc();
        chk("t2_stream", 64'(stream[11:0]), 64'h333);
        chk("t2_vcnt", 64'(vcnt - vbase), 64'd12);
        chk("t2_dcnt", 64'(dcnt - dbase), 64'd1);

        // length 0
        snap();
        xfer(8'hFF, 4'd0, 4'd0);
        chk("t3_done_now", 64'(done_o), 64'd1);
        repeat (3) cyc();
        chk("t3_vcnt", 64'(vcnt - vbase), 64'd0);
        chk("t3_dcnt", 64'(dcnt - dbase), 64'd1);

        // length clamped to WIDTH
        snap();
        xfer(8'hA5, 4'd15, 4'd0);
        repeat (10) cyc();
        chk("t3b_stream", 64'(stream[7:0]), 64'hA5);
        chk("t3b_vcnt", 64'(vcnt - vbase), 64'd8);

        // abort after 3 bits
        snap();
        xfer(8'hFF, 4'd8, 4'd0);
        cyc();
        cyc();
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        chk("t4_ready", 64'(ready_o), 64'd1);
        chk("t4_valid", 64'(dout_valid_o), 64'd0);
        repeat (10) cyc();
        chk("t4_vcnt", 64'(vcnt - vbase), 64'd3);
        chk("t4_dcnt", 64'(dcnt - dbase), 64'd0);

        // start while busy is ignored
        snap();
        xfer(8'h5A, 4'd8, 4'd0);
        cyc();
        start_i = 1'b1;
        pattern_i = 8'hFF;
        cyc();
        start_i = 1'b0;
        repeat (15) cyc();
        chk("t4b_stream", 64'(stream[7:0]), 64'h5A);
        chk("t4b_vcnt", 64'(vcnt - vbase), 64'd8);
        chk("t4b_dcnt", 64'(dcnt - dbase), 64'd1);

        // async reset mid-stream
        xfer(8'hC5, 4'd8, 4'd1);
        repeat (3) cyc();
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t5_ready", 64'(ready_o), 64'd1);
        chk("t5_valid", 64'(dout_valid_o), 64'd0);
        chk("t5_done",  64'(done_o), 64'd0);
        @(negedge clk_i);
        #1 rst_n_i = 1'b1;
        cyc();
        snap();
        xfer(8'h96, 4'd8, 4'd0);
        repeat (10) cyc();
        chk("t5_stream", 64'(stream[7:0]), 64'h96);
        chk("t5_vcnt", 64'(vcnt - vbase), 64'd8);
        chk("t5_dcnt", 64'(dcnt - dbase), 64'd1);

        // start held high: back-to-back length-2 transfers
        snap();
        length_i = 4'd2;
        repeat_cnt_i = 4'd0;
        start_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pattern_i = 8'(i * 37 + 11);
            cyc();
        end
        start_i = 1'b0;
        repeat (6) cyc();
        chk("t6_vcnt", 64'(vcnt - vbase), 64'd6);
        chk("t6_dcnt", 64'(dcnt - dbase), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
- Serial bit-stream transmitter: the source side of the serial-bit interface consumed by the team's sequence detectors.
- Latches a parallel pattern, a bit length and a repeat count on a start handshake.
- Shifts the pattern out MSB-first, one bit per clock, qualified by dout_valid.
- Used as the stimulus/transmit end for detector blocks and as a standalone pattern source.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of length input; must hold WIDTH
REP_W, 4, width of repeat count input

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  request to begin a transfer; accepted only when ready=1
pattern  input  WIDTH  bits to send; active bits are pattern[length-1:0], bit length-1 sent first
length  input  LEN_W  number of bits per pass
repeat_cnt  input  REP_W  extra passes; total passes = repeat_cnt+1
abort  input  1  synchronous cancel of a transfer in progress
ready  output  1  high in IDLE only
dout_bit  output  1  serial data bit; 0 when dout_valid=0
dout_valid  output  1  dout_bit carries a pattern bit this cycle
done  output  1  one-cycle pulse after the final bit of the final pass

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-low; it forces state=IDLE, ready=1, dout_bit=0, dout_valid=0, done=0, and clears all counters and latches. Reset asserted mid-transfer truncates the stream immediately with no done pulse.
- Outputs: all are registered and reflect the current state. No combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1 at edge E0, latch pattern, L = min(length, WIDTH) and R = repeat_cnt. Load bit index = L-1 and pass counter = R.
  - If L=0, go to DONE and emit no bits. Otherwise go to SHIFT.
- SHIFT:
  - dout_valid=1 and dout_bit = latched_pattern[index].
  - If index>0, decrement it.
  - If index=0 and pass counter>0, decrement the pass counter, reload index = L-1 and stay in SHIFT. There is no gap cycle between passes.
  - If index=0 and pass counter=0, go to DONE.
- DONE:
  - done=1, ready=0, dout_valid=0.
  - Unconditionally go to IDLE next cycle.
- Latency and timing:
  - First bit is valid in the cycle after E0.
  - dout_valid is high for exactly L*(R+1) consecutive cycles.
  - done is high for the single cycle after the last valid bit.
  - ready returns high the cycle after done.
  - The earliest restart edge is the one ending the first IDLE cycle.
- start handling: start while ready=0 is ignored and not queued. Input changes after E0 have no effect on the running transfer.
- abort:
  - Sampled in SHIFT only; at that edge go to IDLE.
  - dout_valid and dout_bit drop to 0 in the next cycle. No done pulse.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start wins.
- length>WIDTH is clamped to WIDTH.
- Counters are sized so no wrap occurs for R up to 2^REP_W-1. The maximum stream length is WIDTH*2^REP_W bits.

Test Plan:
1. Reset then single pass: reset low 3 cycles, then high; start with pattern=8'h0A, length=4, repeat_cnt=0 → dout_bit 1,0,1,0 with dout_valid high 4 cycles; done one cycle later; ready high the next cycle. Feeding seq_detector_1010 yields a detection on the 4th bit.
2. Repeats, back-to-back: pattern=8'h03, length=4, repeat_cnt=2 → 12 contiguous valid bits 0011_0011_0011 with no gaps; exactly one done pulse, after bit 12.
3. Boundaries: length=0 → no dout_valid, done in the cycle after E0. length=15 with WIDTH=8 → 8 bits, pattern[7] first.
4. Abort and busy start: start pattern=8'hFF, length=8; assert abort after 3 valid bits → exactly 3 valid bits, no done, ready=1 the next cycle. A start pulse asserted mid-transfer produces no second transfer.
5. Async reset mid-stream: drop reset between clock edges during SHIFT → dout_valid=0 and ready=1 immediately, without waiting for a clock edge. After release, a new start sends a full correct stream.
6. Back-to-back transfers: start held high continuously with length=2, repeat_cnt=0 → repeating cycle of valid, valid, done, IDLE (4 cycles per transfer); each transfer sends the pattern latched at its own accept edge.
